multicycle_exec_unit: RTL and testbench

Parametrised execution unit for the multicycle datapath. It combines the ALU, the shifter and the PSR flag register, and adds sequential shifts and an optional shift-add multiplier. The control FSM issues one operation with a start pulse and waits for done before it uses the result or loads the PSR. Arithmetic, shifts and multiply complete in 1, shamt+1 or WIDTH+1 cycles respectively.

---
 rtl/multicycle_exec_unit.sv | 170 +++++++++++++++++
 tb/tb_multicycle_exec_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_exec_unit.sv
// Execution unit: single-cycle ALU ops, bit-serial shifts and an optional shift-add multiplier.
// Issues on start when idle. Results and PSR are registered and valid in the one-cycle done pulse.
module multicycle_exec_unit #(
  parameter int WIDTH      = 16,
  parameter int SHAMT_BITS = 4,
  parameter bit MUL_EN     = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [3:0]            op_i,
  input  logic [WIDTH-1:0]      src_a_i,
  input  logic [WIDTH-1:0]      src_b_i,
  input  logic [SHAMT_BITS-1:0] shamt_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [WIDTH-1:0]      result_o,
  output logic [WIDTH-1:0]      result_hi_o,
  output logic [7:0]            psr_out_o,
  output logic                  psr_we_o
);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                         OP_XOR = 4'd4, OP_CMP = 4'd5, OP_MOV = 4'd6, OP_LSL = 4'd7,
                         OP_LSR = 4'd8, OP_ASR = 4'd9, OP_MUL = 4'd10;
  localparam int CW = SHAMT_BITS + 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_t;

  state_t               state_q;
  logic                 busy_q, done_q, psr_we_q;
  logic [WIDTH-1:0]     result_q, result_hi_q;
  logic [7:0]           psr_q;
  logic [CW-1:0]        cnt_q;
  logic [3:0]           op_q;
  logic [WIDTH-1:0]     work_q, mcand_q;
  logic [2*WIDTH-1:0]   prod_q;

  logic [WIDTH:0]       add_w, sub_w, mul_sum;
  logic                 add_ovf, sub_ovf, is_shift, is_mul;
  logic [WIDTH-1:0]     res_sc, shift_nx;
  logic [7:0]           psr_sc;
  logic                 we_sc;
  logic [2*WIDTH-1:0]   prod_nx;

  assign add_w   = {1'b0, src_a_i} + {1'b0, src_b_i};
  assign sub_w   = {1'b0, src_a_i} - {1'b0, src_b_i};
  assign add_ovf = (src_a_i[WIDTH-1] == src_b_i[WIDTH-1]) && (add_w[WIDTH-1] != src_a_i[WIDTH-1]);
  assign sub_ovf = (src_a_i[WIDTH-1] != src_b_i[WIDTH-1]) && (sub_w[WIDTH-1] != src_a_i[WIDTH-1]);
  assign is_shift = (op_i == OP_LSL) || (op_i == OP_LSR) || (op_i == OP_ASR);
  assign is_mul   = MUL_EN && (op_i == OP_MUL);

  // One multiplier bit per step: conditionally add multiplicand to the high half, then shift right.
  assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_nx = {mul_sum, prod_q[WIDTH-1:1]};

  always_comb begin
    shift_nx = work_q;
    case (op_q)
      OP_LSL:  shift_nx = {work_q[WIDTH-2:0], 1'b0};
      OP_LSR:  shift_nx = {1'b0, work_q[WIDTH-1:1]};
      default: shift_nx = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    res_sc = '0;
    psr_sc = psr_q;
    we_sc  = 1'b0;
    case (op_i)
      OP_ADD: begin
        res_sc = add_w[WIDTH-1:0]; psr_sc[0] = add_w[WIDTH]; psr_sc[5] = add_ovf; we_sc = 1'b1;
      end
      OP_SUB: begin
        res_sc = sub_w[WIDTH-1:0]; psr_sc[0] = sub_w[WIDTH]; psr_sc[5] = sub_ovf; we_sc = 1'b1;
      end
      OP_AND: res_sc = src_a_i & src_b_i;
      OP_OR:  res_sc = src_a_i | src_b_i;
      OP_XOR: res_sc = src_a_i ^ src_b_i;
      OP_CMP: begin
        res_sc    = src_a_i;
        psr_sc[2] = src_a_i < src_b_i;
        psr_sc[6] = src_a_i == src_b_i;
        psr_sc[7] = $signed(src_a_i) < $signed(src_b_i);
        we_sc     = 1'b1;
      end
      OP_MOV: res_sc = src_b_i;
      OP_LSL, OP_LSR, OP_ASR: res_sc = src_a_i;  // zero shift amount
      default: res_sc = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      psr_we_q    <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      psr_q       <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      work_q      <= '0;
      mcand_q     <= '0;
      prod_q      <= '0;
    end else begin
      done_q   <= 1'b0;
      psr_we_q <= 1'b0;
      case (state_q)
        S_SHIFT: begin
          work_q <= shift_nx;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            result_q    <= shift_nx;
            result_hi_q <= '0;
          end
        end
        S_MUL: begin
          prod_q <= prod_nx;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            result_q    <= prod_nx[WIDTH-1:0];
            result_hi_q <= prod_nx[2*WIDTH-1:WIDTH];
          end
        end
        default: begin  // IDLE and DONE accept a new op identically
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (start_i) begin
            if (is_shift && (shamt_i != '0)) begin
              state_q <= S_SHIFT;
              busy_q  <= 1'b1;
              cnt_q   <= CW'(shamt_i);
              op_q    <= op_i;
              work_q  <= src_a_i;
            end else if (is_mul) begin
              state_q <= S_MUL;
              busy_q  <= 1'b1;
              cnt_q   <= CW'(WIDTH);
              mcand_q <= src_a_i;
              prod_q  <= {{WIDTH{1'b0}}, src_b_i};
            end else begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              result_q    <= res_sc;
              result_hi_q <= '0;
              psr_q       <= psr_sc;
              psr_we_q    <= we_sc;
            end
          end
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign result_hi_o = result_hi_q;
  assign psr_out_o   = psr_q;
  assign psr_we_o    = psr_we_q;

endmodule

// File: tb/tb_multicycle_exec_unit.sv
// Directed scoreboard bench for multicycle_exec_unit; a second instance covers MUL_EN=0.
module tb_multicycle_exec_unit;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4,
                         CMP = 4'd5, MOV = 4'd6, LSL = 4'd7, LSR = 4'd8, ASR = 4'd9,
                         MUL = 4'd10, ILL = 4'd12;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [3:0]  op = '0, shamt = '0;
  logic [15:0] src_a = '0, src_b = '0;
  logic        busy, done, psr_we, nm_busy, nm_done, nm_psr_we;
  logic [15:0] result, result_hi, nm_result, nm_result_hi;
  logic [7:0]  psr, nm_psr;

  multicycle_exec_unit #(.WIDTH(16), .SHAMT_BITS(4), .MUL_EN(1'b1)) u_dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .op_i(op), .src_a_i(src_a),
    .src_b_i(src_b), .shamt_i(shamt), .busy_o(busy), .done_o(done), .result_o(result),
    .result_hi_o(result_hi), .psr_out_o(psr), .psr_we_o(psr_we));

  multicycle_exec_unit #(.WIDTH(16), .SHAMT_BITS(4), .MUL_EN(1'b0)) u_nomul (
    .clk_i(clk), .reset_i(reset), .start_i(start), .op_i(op), .src_a_i(src_a),
    .src_b_i(src_b), .shamt_i(shamt), .busy_o(nm_busy), .done_o(nm_done),
    .result_o(nm_result), .result_hi_o(nm_result_hi), .psr_out_o(nm_psr),
    .psr_we_o(nm_psr_we));

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] res;
    logic [15:0] hi;
    logic [7:0]  psr;
    logic        we;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits for done; poke>0 raises an ADD start at that busy cycle to prove it is dropped.
  task automatic wait_done(input bit chk_nm, input int poke);
    exp_t e;
    int   busy_cnt = 0;
    bit   seen = 1'b0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clk);
      if (chk_nm && n == 1) begin
        chk("nomul_done", nm_done, 1'b1);
        chk("nomul_res", nm_result, 16'h0000);
        chk("nomul_hi", nm_result_hi, 16'h0000);
      end
      if (poke > 0 && n == poke) begin
        op = ADD; src_a = 16'h0001; src_b = 16'h0001; start = 1'b1;
      end
      if (poke > 0 && n == poke + 2) start = 1'b0;
      if (done) begin
        seen = 1'b1;
        e = sb.pop_front();
        chk({e.tag, "_lat"}, n, e.lat);
        chk({e.tag, "_busycyc"}, busy_cnt, e.lat - 1);
        chk({e.tag, "_busy"}, busy, 1'b0);
        chk({e.tag, "_res"}, result, e.res);
        chk({e.tag, "_hi"}, result_hi, e.hi);
        chk({e.tag, "_psr"}, psr, e.psr);
        chk({e.tag, "_we"}, psr_we, e.we);
      end else if (busy) busy_cnt++;
    end
    if (!seen) begin
      chk("done_timeout", 1'b0, 1'b1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    @(negedge clk);
    chk("single_pulse", done, 1'b0);
  endtask

  task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] sh, input logic [15:0] er,
                        input logic [15:0] eh, input logic [7:0] ep, input logic ew,
                        input int lat, input bit chk_nm, input int poke);
    exp_t e;
    e.tag = tag; e.res = er; e.hi = eh; e.psr = ep; e.we = ew; e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    op = o; src_a = a; src_b = b; shamt = sh; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    src_a = 16'($urandom); src_b = 16'($urandom); shamt = 4'($urandom);
    op = 4'($urandom);
    wait_done(chk_nm, poke);
  endtask

  initial begin
    int dcount;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_we", psr_we, 1'b0);
    chk("rst_res", result, 16'h0000);
    chk("rst_hi", result_hi, 16'h0000);
    chk("rst_psr", psr, 8'h00);
    reset = 1'b0;

    run_op("add_ovf",  ADD,  16'h7FFF, 16'h0001, 4'd0, 16'h8000, 16'h0, 8'h20, 1'b1, 1, 0, 0);
    run_op("sub_brw",  SUB,  16'h0001, 16'h0002, 4'd0, 16'hFFFF, 16'h0, 8'h01, 1'b1, 1, 0, 0);
    run_op("cmp_neg",  CMP,  16'h8000, 16'h0001, 4'd0, 16'h8000, 16'h0, 8'h81, 1'b1, 1, 0, 0);
    run_op("cmp_eq",   CMP,  16'h1234, 16'h1234, 4'd0, 16'h1234, 16'h0, 8'h41, 1'b1, 1, 0, 0);
    run_op("add_cy",   ADD,  16'hFFFF, 16'h0001, 4'd0, 16'h0000, 16'h0, 8'h41, 1'b1, 1, 0, 0);
    run_op("sub_ovf",  SUB,  16'h8000, 16'h0001, 4'd0, 16'h7FFF, 16'h0, 8'h60, 1'b1, 1, 0, 0);
    run_op("cmp_lt",   CMP,  16'h0001, 16'h8000, 4'd0, 16'h0001, 16'h0, 8'h24, 1'b1, 1, 0, 0);
    run_op("and",      AND_, 16'hF0F0, 16'hFF00, 4'd0, 16'hF000, 16'h0, 8'h24, 1'b0, 1, 0, 0);
    run_op("or",       OR_,  16'h0F00, 16'h00F0, 4'd0, 16'h0FF0, 16'h0, 8'h24, 1'b0, 1, 0, 0);
    run_op("xor",      XOR_, 16'hAAAA, 16'hFFFF, 4'd0, 16'h5555, 16'h0, 8'h24, 1'b0, 1, 0, 0);
    run_op("mov",      MOV,  16'h1111, 16'hBEEF, 4'd0, 16'hBEEF, 16'h0, 8'h24, 1'b0, 1, 0, 0);
    run_op("asr15",    ASR,  16'h8000, 16'h0000, 4'd15, 16'hFFFF, 16'h0, 8'h24, 1'b0, 16, 0, 0);
    run_op("lsl0",     LSL,  16'h1234, 16'h0000, 4'd0, 16'h1234, 16'h0, 8'h24, 1'b0, 1, 0, 0);
    run_op("lsl4",     LSL,  16'h0001, 16'h0000, 4'd4, 16'h0010, 16'h0, 8'h24, 1'b0, 5, 0, 0);
    run_op("lsr15",    LSR,  16'h8000, 16'h0000, 4'd15, 16'h0001, 16'h0, 8'h24, 1'b0, 16, 0, 0);
    run_op("asr2",     ASR,  16'h4000, 16'h0000, 4'd2, 16'h1000, 16'h0, 8'h24, 1'b0, 3, 0, 0);
    run_op("mul_max",  MUL,  16'hFFFF, 16'hFFFF, 4'd0, 16'h0001, 16'hFFFE, 8'h24, 1'b0, 17, 1, 0);
    run_op("illegal",  ILL,  16'h0005, 16'h0006, 4'd0, 16'h0000, 16'h0, 8'h24, 1'b0, 1, 0, 0);
    run_op("mul_mid",  MUL,  16'h1234, 16'h0010, 4'd0, 16'h2340, 16'h0001, 8'h24, 1'b0, 17, 0, 0);
    run_op("mov_hi0",  MOV,  16'h0000, 16'h0042, 4'd0, 16'h0042, 16'h0, 8'h24, 1'b0, 1, 0, 0);
    run_op("mul_poke", MUL,  16'h0003, 16'h0005, 4'd0, 16'h000F, 16'h0, 8'h24, 1'b0, 17, 0, 3);

    // Reset in the middle of a multiply
    @(negedge clk);
    op = MUL; src_a = 16'h00FF; src_b = 16'h0002; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_res", result, 16'h0000);
    chk("abort_hi", result_hi, 16'h0000);
    chk("abort_psr", psr, 8'h00);
    reset = 1'b0;
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("abort_nodone", dcount, 0);
    run_op("add_after", ADD, 16'h0002, 16'h0003, 4'd0, 16'h0005, 16'h0, 8'h00, 1'b1, 1, 0, 0);

    // Reset and start together: start is dropped
    @(negedge clk);
    reset = 1'b1; start = 1'b1; op = ADD; src_a = 16'h0007; src_b = 16'h0009;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("rststart_done", done, 1'b0);
    chk("rststart_res", result, 16'h0000);
    @(negedge clk);
    chk("rststart_done2", done, 1'b0);
    chk("rststart_busy", busy, 1'b0);

    // Back-to-back single-cycle ops
    @(negedge clk);
    op = ADD; src_a = 16'h0001; src_b = 16'h0001; start = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("tput_done", done, 1'b1);
      chk("tput_res", result, 16'(2 * i));
      chk("tput_we", psr_we, 1'b1);
      src_a = 16'(i + 1); src_b = 16'(i + 1);
      if (i == 3) start = 1'b0;
    end
    @(negedge clk);
    chk("tput_end", done, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
